// File: rtl/pch_fixup.sv
// pch_fixup: program-counter high byte register with branch page-fix FSM.
// State updates on the falling edge of i_clk and is gated by i_clk_en.
// Reset i_reset_n is asynchronous and active-low.
// When a taken branch crosses a page, one extra enabled cycle
// increments or decrements PCH to complete the address.
// Optional: define PCH_FIXUP_COUNT_EN to add o_fix_count.
// o_fix_count is a 16-bit saturating count of IDLE->FIX transitions.
module pch_fixup (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_clk_en,
    input  logic        i_pch_pch,
    input  logic        i_adh_pch,
    input  logic [7:0]  i_adh,
    input  logic        i_pclc,
    input  logic        i_branch,
    input  logic        i_offset_neg,
    input  logic        i_alu_c,
    output logic [7:0]  o_pch,
    output logic        o_pchc,
    output logic        o_fixup_req
`ifdef PCH_FIXUP_COUNT_EN
    ,
    output logic [15:0] o_fix_count
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        FIX  = 1'b1
    } state_t;

    state_t      state;
    logic [7:0]  pch_q;
    logic        dir_q;        // 0: fix by +1 (forward), 1: fix by -1 (backward)
    logic [7:0]  pchs;
    logic [8:0]  inc_sum;
    logic        page_cross;

    // Source select and 9-bit increment path feeding the register and o_pchc
    always_comb begin
        // NOTE: assign a default first so every path drives pchs; this prevents a latch.
        pchs = 8'h00;
        if (i_pch_pch) begin
            pchs = pch_q;
        end else if (i_adh_pch) begin
            pchs = i_adh;
        end
        inc_sum = {1'b0, pchs} + 9'(i_pclc);
    end

    // A branch crosses a page when the low-byte carry disagrees with the offset sign
    assign page_cross = i_offset_neg ^ i_alu_c;

    assign o_pch       = pch_q;
    assign o_fixup_req = (state == FIX);
    assign o_pchc      = (state == IDLE) ? inc_sum[8] : 1'b0;

    // PCH register, latched fix direction and IDLE/FIX state
    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so all registers
            // sample their inputs together at the edge.
            pch_q <= 8'h00;
            dir_q <= 1'b0;
            state <= IDLE;
        end else if (i_clk_en) begin
            case (state)
                IDLE: begin
                    if (i_branch) begin
                        dir_q <= i_offset_neg;
                        if (page_cross) begin
                            state <= FIX;
                        end
                    end else begin
                        pch_q <= inc_sum[7:0];
                    end
                end
                FIX: begin
                    pch_q <= dir_q ? (pch_q - 8'd1) : (pch_q + 8'd1);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PCH_FIXUP_COUNT_EN
    logic [15:0] fix_count_q;

    // Saturating count of page-fix cycles entered
    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            fix_count_q <= 16'h0000;
        end else if (i_clk_en && (state == IDLE) && i_branch && page_cross
                     && (fix_count_q != 16'hFFFF)) begin
            fix_count_q <= fix_count_q + 16'd1;
        end
    end

    assign o_fix_count = fix_count_q;
`endif

endmodule

// File: tb/tb_pch_fixup.sv
// Self-checking bench for pch_fixup: directed cases for increment, wrap,
// branch page fixes, enable gating and mid-fix reset, then random cycles
// compared against a behavioural model of the PC high byte.
`timescale 1ns/1ps
module tb_pch_fixup;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_clk_en;
    logic        i_pch_pch;
    logic        i_adh_pch;
    logic [7:0]  i_adh;
    logic        i_pclc;
    logic        i_branch;
    logic        i_offset_neg;
    logic        i_alu_c;
    logic [7:0]  o_pch;
    logic        o_pchc;
    logic        o_fixup_req;
`ifdef PCH_FIXUP_COUNT_EN
    logic [15:0] o_fix_count;
`endif

    pch_fixup dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_clk_en     (i_clk_en),
        .i_pch_pch    (i_pch_pch),
        .i_adh_pch    (i_adh_pch),
        .i_adh        (i_adh),
        .i_pclc       (i_pclc),
        .i_branch     (i_branch),
        .i_offset_neg (i_offset_neg),
        .i_alu_c      (i_alu_c),
        .o_pch        (o_pch),
        .o_pchc       (o_pchc),
        .o_fixup_req  (o_fixup_req)
`ifdef PCH_FIXUP_COUNT_EN
        ,
        .o_fix_count  (o_fix_count)
`endif
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: PC high byte as an integer plus a pending-fix flag.
    int m_pch;
    bit m_fix;
    bit m_dir;
    int m_cnt;

    task automatic check(input string tag, input int observed, input int expected);
        n_vec++;
        if (observed !== expected) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_pch = 0;
        m_fix = 0;
        m_dir = 0;
        m_cnt = 0;
    endtask

    function automatic int src_value();
        if (i_pch_pch) return m_pch;
        if (i_adh_pch) return int'(i_adh);
        return 0;
    endfunction

    task automatic check_state(input string tag);
        check({tag, ".pch"}, int'(o_pch), m_pch);
        check({tag, ".fixup_req"}, int'(o_fixup_req), int'(m_fix));
`ifdef PCH_FIXUP_COUNT_EN
        check({tag, ".fix_count"}, int'(o_fix_count), m_cnt);
`endif
    endtask

    // Drive one cycle of inputs, check o_pchc before the falling edge,
    // advance the model at the edge, then check registered outputs.
    task automatic apply(input string tag, input bit en, input bit pch_pch,
                         input bit adh_pch, input logic [7:0] adh, input bit pclc,
                         input bit branch, input bit neg, input bit alu_c);
        int sum;
        @(posedge i_clk);
        #1;
        i_clk_en     = en;
        i_pch_pch    = pch_pch;
        i_adh_pch    = adh_pch;
        i_adh        = adh;
        i_pclc       = pclc;
        i_branch     = branch;
        i_offset_neg = neg;
        i_alu_c      = alu_c;
        #1;
        sum = src_value() + int'(pclc);
        check({tag, ".pchc"}, int'(o_pchc), m_fix ? 0 : int'(sum > 255));
        @(negedge i_clk);
        if (en) begin
            if (m_fix) begin
                m_pch = m_dir ? (m_pch + 255) % 256 : (m_pch + 1) % 256;
                m_fix = 0;
            end else if (branch) begin
                m_dir = neg;
                if (neg != alu_c) begin
                    m_fix = 1;
                    if (m_cnt < 65535) m_cnt++;
                end
            end else begin
                m_pch = sum % 256;
            end
        end
        #1;
        check_state(tag);
    endtask

    initial begin
        i_reset_n    = 1'b0;
        i_clk_en     = 1'b0;
        i_pch_pch    = 1'b0;
        i_adh_pch    = 1'b0;
        i_adh        = 8'h00;
        i_pclc       = 1'b0;
        i_branch     = 1'b0;
        i_offset_neg = 1'b0;
        i_alu_c      = 1'b0;
        model_reset();
        #12;
        check_state("reset");
        check("reset.pchc", int'(o_pchc), 0);
        #10;
        i_reset_n = 1'b1;

        // First edge after reset: sources low, pclc=1 loads 0x01
        apply("zero_src", 1, 0, 0, 8'hAA, 1, 0, 0, 0);
        // Increment 0x12 -> 0x13
        apply("load12", 1, 0, 1, 8'h12, 0, 0, 0, 0);
        apply("inc12", 1, 1, 0, 8'h00, 1, 0, 0, 0);
        // Increment wrap 0xFF -> 0x00 with carry
        apply("loadFF", 1, 0, 1, 8'hFF, 0, 0, 0, 0);
        apply("incFF", 1, 1, 0, 8'h00, 1, 0, 0, 0);
        // Forward crossing from 0x20
        apply("load20", 1, 0, 1, 8'h20, 0, 0, 0, 0);
        apply("fwd_br", 1, 1, 1, 8'h55, 1, 1, 0, 1);
        apply("fwd_fix", 1, 1, 0, 8'h00, 1, 1, 1, 0);
        // Backward crossing at 0x00
        apply("load00", 1, 0, 1, 8'h00, 0, 0, 0, 0);
        apply("bwd_br", 1, 0, 0, 8'h00, 0, 1, 1, 0);
        apply("bwd_fix", 1, 0, 1, 8'h77, 1, 0, 0, 0);
        // No crossing
        apply("nocross", 1, 1, 0, 8'h00, 1, 1, 1, 1);
        apply("nocross2", 1, 0, 0, 8'h00, 0, 1, 0, 0);
        // Enable gating in FIX, then asynchronous reset mid-FIX
        apply("load20b", 1, 0, 1, 8'h20, 0, 0, 0, 0);
        apply("gate_br", 1, 0, 0, 8'h00, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) apply("gated", 0, 1, 1, 8'h99, 1, 1, 1, 0);
        @(posedge i_clk);
        #2;
        i_reset_n = 1'b0;
        #1;
        model_reset();
        check_state("midfix_rst");
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        apply("post_rst", 1, 1, 0, 8'h00, 1, 0, 0, 0);

        // Random cycles
        for (int i = 0; i < 400; i++) begin
            apply("rand",
                  ($urandom_range(0, 9) < 8),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  8'($urandom),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) < 4),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
